// File: rtl/mem_wmst_burst.sv
// Buffered write master: a show-ahead FIFO collects user words, and an FSM issues them
// to the memory arbiter in bounded bursts, with a byte-enable mask on a partial last beat.
module mem_wmst_burst #(
  parameter int DW           = 128,
  parameter int AW           = 32,
  parameter int DEPTH        = 256,
  parameter int AFULL_MARGIN = 6,
  parameter int BURST_MAX    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          write_control_fixed_location,
  input  logic [AW-1:0]                 write_control_write_base,
  input  logic [31:0]                   write_control_write_length,
  input  logic                          write_control_go,
  output logic                          write_control_done,
  input  logic                          write_user_write_buffer,
  input  logic [DW-1:0]                 write_user_buffer_input_data,
  output logic                          write_user_buffer_full,
  output logic                          write_user_overflow,
  output logic                          wreq,
  input  logic                          wrdy,
  output logic                          wena,
  output logic [AW-$clog2(DW/8)-1:0]    waddr,
  output logic [DW-1:0]                 wdata,
  output logic [DW/8-1:0]               wbe
);
  localparam int BYTES = DW / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int PW    = $clog2(DEPTH);
  localparam int UW    = PW + 1;
  localparam int WAW   = AW - BSH;
  localparam int BCW   = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP, S_LAST} state_t;

  function automatic logic [BYTES-1:0] tail_mask(input logic [BSH-1:0] r);
    logic [BYTES-1:0] m;
    for (int i = 0; i < BYTES; i++) m[i] = (i < int'(r));
    return m;
  endfunction

  state_t            state_q, state_d;
  logic [DW-1:0]     mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [UW-1:0]     used_q;
  logic              ovf_q;
  logic [31:0]       beats_q;
  logic [BSH-1:0]    rem_q;
  logic [WAW-1:0]    addr_q;
  logic              fixed_q;
  logic [BCW-1:0]    bcnt_q;
  logic              wena_q;
  logic [WAW-1:0]    waddr_q;
  logic [DW-1:0]     wdata_q;
  logic [BYTES-1:0]  wbe_q;

  logic              push_ok, empty, fire, go_ok;
  logic [DW-1:0]     head;
  logic [32:0]       len_plus;
  logic              unused_base_lo;

  assign unused_base_lo = ^write_control_write_base[BSH-1:0];

  assign push_ok  = write_user_write_buffer && (used_q < UW'(DEPTH));
  assign empty    = (used_q == '0);
  assign head     = mem_q[rptr_q];
  assign go_ok    = (state_q == S_IDLE) && write_control_go && (write_control_write_length != 32'd0);
  assign fire     = (state_q == S_XFER) && wrdy && !empty && (beats_q != 32'd0);
  assign len_plus = {1'b0, write_control_write_length} + 33'(BYTES - 1);

  // FIFO storage (data only, never reset)
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= write_user_buffer_input_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      used_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (fire)    rptr_q <= rptr_q + PW'(1);
      if (write_user_write_buffer && !push_ok) ovf_q <= 1'b1;
      case ({push_ok, fire})
        2'b10:   used_q <= used_q + UW'(1);
        2'b01:   used_q <= used_q - UW'(1);
        default: used_q <= used_q;
      endcase
    end
  end

  assign write_user_buffer_full = (used_q >= UW'(DEPTH - AFULL_MARGIN));
  assign write_user_overflow    = ovf_q;

  always_comb begin
    state_d            = state_q;
    wreq               = 1'b0;
    write_control_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        write_control_done = 1'b1;
        if (go_ok) state_d = S_XFER;
      end
      S_XFER: begin
        wreq = 1'b1;
        if (fire) begin
          if (beats_q == 32'd1)                      state_d = S_LAST;
          else if (bcnt_q == BCW'(BURST_MAX - 1))    state_d = S_GAP;
        end
      end
      S_GAP:  state_d = S_XFER;
      S_LAST: begin
        write_control_done = 1'b1;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beats_q <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      fixed_q <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (go_ok) begin
        beats_q <= 32'(len_plus >> BSH);
        rem_q   <= write_control_write_length[BSH-1:0];
        addr_q  <= write_control_write_base[AW-1:BSH];
        fixed_q <= write_control_fixed_location;
        bcnt_q  <= '0;
      end else if (fire) begin
        beats_q <= beats_q - 32'd1;
        bcnt_q  <= bcnt_q + BCW'(1);
        if (!fixed_q) addr_q <= addr_q + WAW'(1);
      end else if (state_q == S_GAP) begin
        bcnt_q <= '0;
      end
    end
  end

  // Beat output stage: registered one cycle after the fire cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wena_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wbe_q   <= '0;
    end else begin
      wena_q <= fire;
      if (fire) begin
        waddr_q <= addr_q;
        wdata_q <= head;
        wbe_q   <= (beats_q == 32'd1 && rem_q != '0) ? tail_mask(rem_q) : '1;
      end
    end
  end

  assign wena  = wena_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign wbe   = wbe_q;

endmodule

// File: tb/tb_mem_wmst_burst.sv
// Scoreboard bench for mem_wmst_burst: stimulus pushes expected beats and data words,
// a forked monitor pops and compares on every wena.
module tb_mem_wmst_burst;
  localparam int DW = 128, AW = 32, DEPTH = 16, AFM = 6, BMAX = 4;
  localparam int BYTES = DW / 8, BSH = 4, WAW = AW - BSH;

  typedef struct {
    logic [WAW-1:0]   addr;
    logic [BYTES-1:0] be;
    bit               last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fixed_loc;
  logic [AW-1:0]    base;
  logic [31:0]      len;
  logic             go;
  logic             done;
  logic             push;
  logic [DW-1:0]    din;
  logic             full;
  logic             ovf;
  logic             wreq;
  logic             wrdy;
  logic             wena;
  logic [WAW-1:0]   waddr;
  logic [DW-1:0]    wdata;
  logic [BYTES-1:0] wbe;

  mem_wmst_burst #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .AFULL_MARGIN(AFM), .BURST_MAX(BMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .write_control_fixed_location(fixed_loc),
    .write_control_write_base(base),
    .write_control_write_length(len),
    .write_control_go(go),
    .write_control_done(done),
    .write_user_write_buffer(push),
    .write_user_buffer_input_data(din),
    .write_user_buffer_full(full),
    .write_user_overflow(ovf),
    .wreq(wreq), .wrdy(wrdy), .wena(wena),
    .waddr(waddr), .wdata(wdata), .wbe(wbe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL global_timeout cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  beat_t         eq[$];
  logic [DW-1:0] dq[$];
  int            gap_q[$];
  int            wena_cyc[$];
  int            checks = 0, errors = 0;
  int            beat_cnt = 0;
  bit            model_busy = 0, model_ovf = 0;
  logic          prev_wrdy = 1'b0;
  beat_t         b_mon;
  logic [DW-1:0] d_mon;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void model_push(input logic [DW-1:0] d);
    if (dq.size() < DEPTH) dq.push_back(d);
    else model_ovf = 1;
  endfunction

  // A transfer is the list of beats: consecutive (or fixed) word addresses from base,
  // full byte enables except a partial final beat.
  function automatic void model_go(input logic [AW-1:0] b, input logic [31:0] l, input bit fx);
    int    nb;
    beat_t bt;
    if (model_busy || l == 0) return;
    nb = int'((l + 32'(BYTES - 1)) / BYTES);
    for (int k = 0; k < nb; k++) begin
      bt.addr = fx ? WAW'(b / BYTES) : WAW'(b / BYTES + k);
      bt.be   = (k == nb - 1 && (l % BYTES) != 0) ? BYTES'((1 << (l % BYTES)) - 1) : '1;
      bt.last = (k == nb - 1);
      eq.push_back(bt);
    end
    model_busy = 1;
  endfunction

  task automatic push_word(input logic [DW-1:0] d);
    push = 1'b1;
    din  = d;
    model_push(d);
    tick;
    push = 1'b0;
  endtask

  task automatic start(input logic [AW-1:0] b, input logic [31:0] l, input bit fx);
    base = b; len = l; fixed_loc = fx; go = 1'b1;
    model_go(b, l, fx);
    tick;
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int n = 0;
    while ((model_busy || !done) && n < budget) begin
      if (rnd) wrdy = 1'($urandom_range(0, 1));
      tick;
      n++;
    end
    wrdy = 1'b1;
    tick; tick;
    checks++;
    if (model_busy || eq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL idle_wait busy=%0d beats_left=%0d words_left=%0d required=0/0/0",
               model_busy, eq.size(), dq.size());
      eq.delete(); dq.delete(); model_busy = 0; beat_cnt = 0;
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({wreq, wena, waddr, wdata, wbe, done, full, ovf} !==
        {1'b0, 1'b0, {WAW{1'b0}}, {DW{1'b0}}, {BYTES{1'b0}}, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s wreq=%b wena=%b waddr=%h wdata=%h wbe=%h done=%b full=%b ovf=%b required=0,0,0,0,0,1,0,0",
               name, wreq, wena, waddr, wdata, wbe, done, full, ovf);
    end
  endtask

  initial begin
    rst_n = 1'b0; fixed_loc = 1'b0; base = '0; len = '0; go = 1'b0;
    push = 1'b0; din = '0; wrdy = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (wena) begin
            checks++;
            if (eq.size() == 0 || dq.size() == 0) begin
              errors++;
              $display("FAIL unexpected_wena waddr=%h wdata=%h required=no_beat", waddr, wdata);
            end else begin
              b_mon = eq.pop_front();
              d_mon = dq.pop_front();
              if (waddr !== b_mon.addr || wbe !== b_mon.be || wdata !== d_mon ||
                  done !== b_mon.last || prev_wrdy !== 1'b1) begin
                errors++;
                $display("FAIL beat addr=%h/%h be=%h/%h data=%h/%h done=%b/%b prev_wrdy=%b/1 (actual/required)",
                         waddr, b_mon.addr, wbe, b_mon.be, wdata, d_mon, done, b_mon.last, prev_wrdy);
              end
              beat_cnt++;
              if (b_mon.last) begin
                beat_cnt   = 0;
                model_busy = 0;
              end
            end
            wena_cyc.push_back(cyc);
          end
          if (!done && !wreq) gap_q.push_back(beat_cnt);
          prev_wrdy = wrdy;
        end
      end
    join_none

    tick; tick; tick;
    check_reset_vals("reset_state");
    rst_n = 1'b1;
    tick;

    // Basic transfer
    wrdy = 1'b1;
    for (int i = 0; i < 4; i++) push_word({$urandom, $urandom, $urandom, $urandom});
    wena_cyc.delete(); gap_q.delete();
    start(32'h1000, 32'd64, 1'b0);
    wait_idle(50, 1'b0);
    checks++;
    if (wena_cyc.size() != 4 || wena_cyc[3] - wena_cyc[0] != 3 || gap_q.size() != 0) begin
      errors++;
      $display("FAIL basic_back_to_back beats=%0d span=%0d gaps=%0d required=4/3/0",
               wena_cyc.size(), wena_cyc.size() == 4 ? wena_cyc[3] - wena_cyc[0] : -1, gap_q.size());
    end

    // Partial last beat, fixed location, address wrap
    for (int i = 0; i < 3; i++) push_word({$urandom, $urandom, $urandom, $urandom});
    start(32'h3000, 32'd40, 1'b0);
    wait_idle(50, 1'b0);
    for (int i = 0; i < 3; i++) push_word({$urandom, $urandom, $urandom, $urandom});
    start(32'h2000, 32'd48, 1'b1);
    wait_idle(50, 1'b0);
    for (int i = 0; i < 4; i++) push_word({$urandom, $urandom, $urandom, $urandom});
    start(32'hFFFF_FFE0, 32'd64, 1'b0);
    wait_idle(50, 1'b0);

    // Zero-length go stays idle
    start(32'h4000, 32'd0, 1'b0);
    checks++;
    if (done !== 1'b1 || wreq !== 1'b0) begin
      errors++;
      $display("FAIL zero_len done=%b wreq=%b required=1/0", done, wreq);
    end
    tick; tick;

    // Burst gap
    for (int i = 0; i < 10; i++) push_word({$urandom, $urandom, $urandom, $urandom});
    gap_q.delete();
    start(32'h5000, 32'd160, 1'b0);
    wait_idle(80, 1'b0);
    checks++;
    if (gap_q.size() != 2 || gap_q[0] != 4 || gap_q[1] != 8) begin
      errors++;
      $display("FAIL burst_gap count=%0d first=%0d second=%0d required=2/4/8",
               gap_q.size(), gap_q.size() > 0 ? gap_q[0] : -1, gap_q.size() > 1 ? gap_q[1] : -1);
    end

    // Stall: wrdy toggles, sparse pushes, go while busy
    begin
      int np = 0;
      start(32'h6000, 32'd128, 1'b0);
      for (int c = 0; c < 60; c++) begin
        wrdy = 1'(c % 2);
        push = 1'b0;
        go   = 1'b0;
        if (c % 3 == 0 && np < 8) begin
          din  = {$urandom, $urandom, $urandom, $urandom};
          push = 1'b1;
          model_push(din);
          np++;
        end
        if (c == 10) begin
          checks++;
          if (done !== 1'b0) begin
            errors++;
            $display("FAIL stall_busy done=%b required=0", done);
          end
          base = 32'h7000; len = 32'd32; fixed_loc = 1'b0; go = 1'b1;
          model_go(base, len, 1'b0);
        end
        tick;
      end
      push = 1'b0; go = 1'b0;
      wait_idle(100, 1'b0);
    end

    // Randomized transfers
    for (int t = 0; t < 8; t++) begin
      int n;
      logic [31:0] l;
      n = $urandom_range(1, DEPTH);
      l = 32'($urandom_range((n - 1) * BYTES + 1, n * BYTES));
      for (int i = 0; i < n; i++) push_word({$urandom, $urandom, $urandom, $urandom});
      start($urandom, l, 1'($urandom_range(0, 1)));
      wait_idle(400, 1'b1);
    end

    // Almost-full and overflow
    for (int i = 1; i <= 17; i++) begin
      push_word({$urandom, $urandom, $urandom, $urandom});
      if (i == 9 || i == 10) begin
        checks++;
        if (full !== (dq.size() >= DEPTH - AFM)) begin
          errors++;
          $display("FAIL afull_after_%0d full=%b required=%b", i, full, dq.size() >= DEPTH - AFM);
        end
      end
      if (i == 16 || i == 17) begin
        checks++;
        if (ovf !== model_ovf) begin
          errors++;
          $display("FAIL overflow_after_%0d ovf=%b required=%b", i, ovf, model_ovf);
        end
      end
    end
    wrdy = 1'b1;
    start(32'h8000, 32'd256, 1'b0);
    wait_idle(200, 1'b0);

    // Reset mid-transfer
    for (int i = 0; i < 16; i++) push_word({$urandom, $urandom, $urandom, $urandom});
    start(32'h9000, 32'd256, 1'b0);
    for (int i = 0; i < 5; i++) tick;
    #2;
    rst_n = 1'b0;
    eq.delete(); dq.delete(); model_busy = 0; beat_cnt = 0; model_ovf = 0;
    #1;
    check_reset_vals("reset_mid_xfer");
    tick; tick;
    rst_n = 1'b1;
    wena_cyc.delete();
    for (int i = 0; i < 20; i++) tick;
    checks++;
    if (wena_cyc.size() != 0 || done !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet wena_count=%0d done=%b ovf=%b required=0/1/0",
               wena_cyc.size(), done, ovf);
    end
    push_word({$urandom, $urandom, $urandom, $urandom});
    start(32'hA000, 32'd16, 1'b0);
    wait_idle(50, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wmst_burst.md
# mem_wmst_burst

Parametrised buffered write master: a successor to the fixed 128-bit/256-deep write master, driven by the same control/user port pair as the conv engine's output stage. It buffers user data in an internal FIFO of configurable width and depth, then issues beats to the memory-side arbiter through the `wreq`/`wrdy` handshake. Compared with the previous generation it adds:

- byte-granular lengths, with a last-beat byte-enable mask;
- fixed-location mode;
- bounded bursts with arbiter release;
- empty-safe pops;
- an overflow flag.

## Interface

Parameters:
- `DW`, default 128: data width in bits; power of two, ≥16. `BYTES` = `DW`/8, `BSH` = log2(`BYTES`).
- `AW`, default 32: width of the byte base address and of `waddr`.
- `DEPTH`, default 256: FIFO depth in words; power of two.
- `AFULL_MARGIN`, default 6: `write_user_buffer_full` asserts when used ≥ `DEPTH`−`AFULL_MARGIN`.
- `BURST_MAX`, default 16: maximum consecutive beats per `wreq` grant; ≥1.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `write_control_fixed_location`, in, 1: when 1, `waddr` holds at base for every beat.
- `write_control_write_base`, in, `AW`: byte base address.
- `write_control_write_length`, in, 32: length in bytes.
- `write_control_go`, in, 1: one-cycle start pulse.
- `write_control_done`, out, 1: 1 when idle.
- `write_user_write_buffer`, in, 1: FIFO push.
- `write_user_buffer_input_data`, in, `DW`: push data.
- `write_user_buffer_full`, out, 1: almost-full back-pressure.
- `write_user_overflow`, out, 1: sticky; set when a push arrives while the FIFO is full.
- `wreq`, out, 1: arbiter request.
- `wrdy`, in, 1: arbiter grant/ready.
- `wena`, out, 1: write strobe.
- `waddr`, out, `AW`−`BSH`: word address.
- `wdata`, out, `DW`: write data.
- `wbe`, out, `BYTES`: byte enables.

## Operation

**FIFO**
- Inferred RAM/register FIFO with show-ahead output; `used` counter is log2(`DEPTH`)+1 bits.
- Push is accepted only if `used` < `DEPTH`.
- A push at `used` = `DEPTH` is dropped and sets `write_user_overflow`. The flag clears only on reset.
- Simultaneous push and pop leaves `used` unchanged.

**Start (on `go` in IDLE)**
- Latches `beats_left` = ceil(length/`BYTES`).
- Latches `rem` = length mod `BYTES`.
- Latches word address = base >> `BSH`.
- Latches the fixed flag.
- Clears `burst_cnt`.
- A `go` outside IDLE is ignored.
- A `go` with length 0 leaves the block in IDLE with done = 1.

**State machine**
- IDLE: `done` = 1, `wreq` = 0. On a valid `go`: `done` ← 0, `wreq` ← 1, go to XFER.
- XFER: a beat fires when `wrdy` & !empty & `beats_left` > 0. Each beat:
  - pops the FIFO;
  - decrements `beats_left`;
  - increments `burst_cnt`.
- XFER exits:
  - Beat with `beats_left` = 1 → LAST.
  - Beat that makes `burst_cnt` = `BURST_MAX` with beats remaining → GAP.
- GAP: `wreq` = 0 for exactly one cycle, `burst_cnt` ← 0, then `wreq` = 1 and back to XFER.
- LAST: `wreq` ← 0, `done` ← 1, go to IDLE.

**Beat outputs** (registered one cycle after the fire cycle)
- `wena` = 1.
- `wdata` = FIFO head at the fire cycle.
- `waddr` = current word address.
- `wbe` = all ones, except on the last beat when `rem` ≠ 0: `wbe` = (1 << `rem`) − 1.
- The word address increments by 1 after each beat unless fixed. It wraps modulo 2^(`AW`−`BSH`).
- `wdata`, `waddr` and `wbe` hold their values when `wena` = 0.

## Timing

- Reset values: `wreq` 0, `wena` 0, `waddr` 0, `wdata` 0, `wbe` 0, `write_control_done` 1, `write_user_buffer_full` 0, `write_user_overflow` 0. The FIFO is empty.
- `go` at cycle T: `done` falls and `wreq` rises at T+1. The first beat can fire at T+1 if `wrdy` and data are present; its `wena` is at T+2.
- Throughput: one beat per cycle while `wrdy` & !empty, except one idle cycle per GAP.
- `wena` of the last beat and the rise of `done` occur in the same cycle (the cycle after the last fire).
- `write_user_buffer_full` is combinational from `used`; it reflects a push one cycle after that push.
- `wrdy` low or FIFO empty stalls without losing state. `wreq` stays high during the stall.
- `rst_n` low mid-transfer aborts immediately:
  - all outputs return to their reset values;
  - FIFO contents are discarded;
  - no further `wena` is issued.

## Test plan

- **Basic transfer.** `DW`=128; preload 4 words A0..A3; `wrdy`=1; base 0x1000, length 64, `go`.
  - Required: 4 consecutive `wena` with `waddr` 0x100..0x103, `wdata` A0..A3, `wbe` 0xFFFF.
  - Required: `done` rises in the cycle of the 4th `wena`.
- **Partial last beat.** Length 40.
  - Required: 3 beats with `wbe` 0xFFFF, 0xFFFF, 0x00FF.
- **Fixed location.** `fixed_location`=1, length 48, base 0x2000.
  - Required: 3 beats, all with `waddr` 0x200.
- **Burst gap.** `BURST_MAX`=4, length 160, FIFO preloaded with 10 words.
  - Required: `wreq` low for exactly one cycle after beats 4 and 8.
  - Required: 10 beats total, `done` after beat 10.
- **Stall.** `wrdy` toggles every cycle; one word pushed every 3 cycles.
  - Required: `wena` only when both `wrdy` and data were available; data order preserved.
  - Required: a `go` issued while busy is ignored.
- **Full/reset.**
  - `DEPTH`=16, `AFULL_MARGIN`=6, no `go`: after 10 pushes `full`=1; the 17th push sets `overflow`=1.
  - Start a 16-beat transfer and pulse `rst_n` low mid-transfer: all outputs reach their reset values, `done`=1, and no `wena` follows.
